mux_n_pipe: RTL and testbench

//  Parametrised N-input, WIDTH-bit selector with one registered output stage and

---
 rtl/mux_n_pipe.sv | 93 +++++++++
 tb/tb_mux_n_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
// N-input WIDTH-bit selector with one handshaked output register stage.
// Optional sticky out-of-range select flag: define MUX_N_SEL_ERR_EN.
module mux_n_pipe #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned N_IN      = 8,
  parameter int unsigned CONST_IDX = 7,
  parameter int unsigned CONST_VAL = 227,
  localparam int unsigned SEL_W    = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_IN*WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      data_out,
  output logic [SEL_W-1:0]      sel_q,
  output logic                  out_valid,
`ifdef MUX_N_SEL_ERR_EN
  output logic                  sel_err,
`endif
  input  logic                  out_ready
);

  localparam logic [WIDTH-1:0] CONST_W = WIDTH'(CONST_VAL);
  localparam bit HAS_CONST = (CONST_IDX < N_IN);

  logic [31:0]      sel_i;
  logic [WIDTH-1:0] pick;
  logic             accept;

  logic [WIDTH-1:0] data_out_d, data_out_q;
  logic [SEL_W-1:0] sel_d;
  logic             out_valid_d, out_valid_q;

  // Out-of-range indices fall through to slice 0
  always_comb begin
    sel_i = 32'(sel);
    pick  = data_in[WIDTH-1:0];
    for (int unsigned i = 1; i < N_IN; i++) begin
      if (sel_i == 32'(i)) pick = data_in[i*WIDTH +: WIDTH];
    end
    if (HAS_CONST && sel_i == CONST_IDX) pick = CONST_W;
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    data_out_d  = data_out_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      data_out_d  = pick;
      sel_d       = sel;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q  <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

`ifdef MUX_N_SEL_ERR_EN
  logic sel_err_d, sel_err_q;

  always_comb begin
    sel_err_d = sel_err_q;
    if (accept && sel_i >= N_IN) sel_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_err_q <= 1'b0;
    else       sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe: an 8-input instance with the constant
// channel and a 6-input instance exercising out-of-range selects.
module tb_mux_n_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]   sel_a, sel_b;
  logic [255:0] din_a;
  logic [191:0] din_b;
  logic         iv_a, ir_a, ov_a, or_a;
  logic         iv_b, ir_b, ov_b, or_b;
  logic [31:0]  do_a, do_b;
  logic [2:0]   sq_a, sq_b;
`ifdef MUX_N_SEL_ERR_EN
  logic         se_a, se_b;
`endif

  mux_n_pipe #(.WIDTH(32), .N_IN(8)) u_a (
    .clk(clk), .reset(reset), .sel(sel_a), .data_in(din_a),
    .in_valid(iv_a), .in_ready(ir_a), .data_out(do_a), .sel_q(sq_a),
    .out_valid(ov_a),
`ifdef MUX_N_SEL_ERR_EN
    .sel_err(se_a),
`endif
    .out_ready(or_a)
  );

  mux_n_pipe #(.WIDTH(32), .N_IN(6)) u_b (
    .clk(clk), .reset(reset), .sel(sel_b), .data_in(din_b),
    .in_valid(iv_b), .in_ready(ir_b), .data_out(do_b), .sel_q(sq_b),
    .out_valid(ov_b),
`ifdef MUX_N_SEL_ERR_EN
    .sel_err(se_b),
`endif
    .out_ready(or_b)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [34:0] q_a[$];
  logic [34:0] q_b[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && ov_a && or_a) begin
      if (q_a.size() == 0) chk("a_unexpected_word", 64'(do_a), 64'hx);
      else begin
        logic [34:0] e;
        e = q_a.pop_front();
        chk("a_data", 64'(do_a), 64'(e[34:3]));
        chk("a_selq", 64'(sq_a), 64'(e[2:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ov_b && or_b) begin
      if (q_b.size() == 0) chk("b_unexpected_word", 64'(do_b), 64'hx);
      else begin
        logic [34:0] e;
        e = q_b.pop_front();
        chk("b_data", 64'(do_b), 64'(e[34:3]));
        chk("b_selq", 64'(sq_b), 64'(e[2:0]));
      end
    end
  end

  task automatic send_a(input logic [2:0] s, input logic [31:0] exp);
    int n;
    n = 0;
    sel_a = s;
    iv_a = 1'b1;
    while (!ir_a && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ir_a) chk("a_send_timeout", 64'(ir_a), 64'd1);
    else q_a.push_back({exp, s});
    @(posedge clk); #1;
    iv_a = 1'b0;
  endtask

  task automatic send_b(input logic [2:0] s, input logic [31:0] exp);
    sel_b = s;
    iv_b = 1'b1;
    if (!ir_b) chk("b_ready", 64'(ir_b), 64'd1);
    else q_b.push_back({exp, s});
    @(posedge clk); #1;
    iv_b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    sel_a = 3'd0; sel_b = 3'd0;
    or_a = 1'b1; or_b = 1'b1;
    iv_a = 1'b1; iv_b = 1'b0;
    for (int i = 0; i < 8; i++) din_a[i*32 +: 32] = 32'h1000_0000 + i;
    din_a[7*32 +: 32] = 32'hDEAD_BEEF;
    for (int i = 0; i < 6; i++) din_b[i*32 +: 32] = 32'h2000_0000 + i;

    // Reset held with in_valid asserted
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 64'(do_a), 64'd0);
    chk("rst_valid", 64'(ov_a), 64'd0);
    chk("rst_ready", 64'(ir_a), 64'd1);
    chk("rst_selq", 64'(sq_a), 64'd0);
`ifdef MUX_N_SEL_ERR_EN
    chk("rst_selerr", 64'(se_b), 64'd0);
`endif
    iv_a = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", 64'(ov_a), 64'd0);

    // Back-to-back sel 0..6, then the constant channel
    for (int i = 0; i <= 6; i++) begin
      send_a(3'(i), 32'h1000_0000 + i);
      chk("b2b_valid", 64'(ov_a), 64'd1);
    end
    send_a(3'd7, 32'd227);
    chk("const_valid", 64'(ov_a), 64'd1);
    @(posedge clk); #1;
    chk("drain_valid", 64'(ov_a), 64'd0);

    // Stall with changing inputs
    or_a = 1'b0;
    send_a(3'd2, 32'h1000_0002);
    iv_a = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sel_a = 3'(c + 4);
      din_a[2*32 +: 32] = 32'hBAD0_0000 + c;
      chk("stall_ready", 64'(ir_a), 64'd0);
      @(posedge clk); #1;
      chk("stall_data", 64'(do_a), 64'h1000_0002);
      chk("stall_selq", 64'(sq_a), 64'd2);
      chk("stall_valid", 64'(ov_a), 64'd1);
    end
    iv_a = 1'b0;
    or_a = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", 64'(ov_a), 64'd0);

    // 6-input instance: out-of-range selects map to slice 0
    send_b(3'd5, 32'h2000_0005);
`ifdef MUX_N_SEL_ERR_EN
    chk("selerr_clear", 64'(se_b), 64'd0);
`endif
    send_b(3'd7, 32'h2000_0000);
`ifdef MUX_N_SEL_ERR_EN
    chk("selerr_set", 64'(se_b), 64'd1);
`endif
    send_b(3'd3, 32'h2000_0003);
    send_b(3'd6, 32'h2000_0000);
    send_b(3'd1, 32'h2000_0001);
`ifdef MUX_N_SEL_ERR_EN
    chk("selerr_sticky", 64'(se_b), 64'd1);
    chk("selerr_a", 64'(se_a), 64'd0);
`endif
    @(posedge clk); #1;

    // Async reset while a word is stalled
    or_a = 1'b0;
    send_a(3'd4, 32'h1000_0004);
    chk("pre_rst_valid", 64'(ov_a), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 64'(ov_a), 64'd0);
    chk("async_data", 64'(do_a), 64'd0);
`ifdef MUX_N_SEL_ERR_EN
    chk("async_selerr", 64'(se_b), 64'd0);
`endif
    q_a.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    or_a = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_valid", 64'(ov_a), 64'd0);
    end

    // First accept after reset appears one cycle later
    send_a(3'd1, 32'h1000_0001);
    chk("post_rst_accept", 64'(ov_a), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_a_empty", 64'(q_a.size()), 64'd0);
    chk("queue_b_empty", 64'(q_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
